// File: rtl/shift_pkg.sv
// Shared types and constants for the multi-step rotate controller.
package shift_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        OUT   = 2'b10
    } state_e;

    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_CNT_W = 3;

    // True when no more than one shifter control line is asserted.
    function automatic logic ctrl_onehot0(input logic fb, input logic fl, input logic fr);
        return !((fb & fl) | (fb & fr) | (fl & fr));
    endfunction

endpackage

// File: rtl/shift_seq_chk.sv
// Invariant checker for the shifter control lines driven by shift_seq.
module shift_seq_chk
    import shift_pkg::*;
(
    input logic clk,
    input logic rst,
    input logic fbus,
    input logic flbus,
    input logic frbus,
    input logic busy,
    input logic done
);

    a_ctrl_onehot0: assert property (@(posedge clk) disable iff (rst)
        ctrl_onehot0(fbus, flbus, frbus))
        else $error("shifter control lines not one-hot-or-zero");

    a_done_in_out: assert property (@(posedge clk) disable iff (rst)
        done |-> (fbus && busy))
        else $error("done asserted outside pass-through cycle");

endmodule

// File: rtl/shift_seq.sv
// Multi-step rotate controller: sequences the single-bit bus shifter for
// cnt steps, feeding each result back, then passes the final value through.
module shift_seq
    import shift_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             dir,
    input  logic [CNT_W-1:0] cnt,
    input  logic [WIDTH-1:0] din,
    input  logic [WIDTH-1:0] sh_w,
    input  logic             sh_cf,
    output logic [WIDTH-1:0] sh_a,
    output logic             fbus,
    output logic             flbus,
    output logic             frbus,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] dout,
    output logic             cf
);

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    state_e             state_r, state_s;
    logic [WIDTH-1:0]   acc_r, acc_s;
    logic [CNT_W-1:0]   rem_r, rem_s;
    logic               dir_r, dir_s;
    logic               cf_r, cf_s;
    logic [WIDTH-1:0]   dout_r, dout_s;
    logic               fbus_r, flbus_r, frbus_r, busy_r, done_r;
    logic               fbus_s, flbus_s, frbus_s, busy_s, done_s;

    // Next-state and datapath update; the unused state code falls back to IDLE.
    always_comb begin
        state_s = IDLE;
        acc_s   = acc_r;
        rem_s   = rem_r;
        dir_s   = dir_r;
        cf_s    = cf_r;
        dout_s  = dout_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    acc_s   = din;
                    dir_s   = dir;
                    rem_s   = cnt;
                    cf_s    = 1'b0;
                    state_s = (cnt != CNT_ZERO) ? SHIFT : OUT;
                end else begin
                    state_s = IDLE;
                end
            end
            SHIFT: begin
                acc_s   = sh_w;
                cf_s    = sh_cf;
                rem_s   = rem_r - CNT_ONE;
                state_s = (rem_r == CNT_ONE) ? OUT : SHIFT;
            end
            OUT: begin
                dout_s  = acc_r;
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // Control lines are decoded from the upcoming state so they register as Moore outputs.
    always_comb begin
        fbus_s  = (state_s == OUT);
        flbus_s = (state_s == SHIFT) && (dir_s == DIR_LEFT);
        frbus_s = (state_s == SHIFT) && (dir_s == DIR_RIGHT);
        busy_s  = (state_s != IDLE);
        done_s  = (state_s == OUT);
    end

    // State, datapath and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            acc_r   <= {WIDTH{1'b0}};
            rem_r   <= CNT_ZERO;
            dir_r   <= 1'b0;
            cf_r    <= 1'b0;
            dout_r  <= {WIDTH{1'b0}};
            fbus_r  <= 1'b0;
            flbus_r <= 1'b0;
            frbus_r <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            acc_r   <= acc_s;
            rem_r   <= rem_s;
            dir_r   <= dir_s;
            cf_r    <= cf_s;
            dout_r  <= dout_s;
            fbus_r  <= fbus_s;
            flbus_r <= flbus_s;
            frbus_r <= frbus_s;
            busy_r  <= busy_s;
            done_r  <= done_s;
        end
    end

    assign sh_a  = acc_r;
    assign fbus  = fbus_r;
    assign flbus = flbus_r;
    assign frbus = frbus_r;
    assign busy  = busy_r;
    assign done  = done_r;
    assign dout  = dout_r;
    assign cf    = cf_r;

    shift_seq_chk u_chk (
        .clk   (clk),
        .rst   (rst),
        .fbus  (fbus_r),
        .flbus (flbus_r),
        .frbus (frbus_r),
        .busy  (busy_r),
        .done  (done_r)
    );

endmodule

// File: tb/tb_shift_seq.sv
// Closed-loop bench: behavioural shifter wired back to shift_seq, scoreboard
// of expected results and per-cycle control-line expectations.
module tb_shift_seq;

    localparam int W  = 8;
    localparam int CW = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          dir = 1'b0;
    logic [CW-1:0] cnt = '0;
    logic [W-1:0]  din = '0;
    logic [W-1:0]  sh_w;
    logic          sh_cf;
    logic [W-1:0]  sh_a;
    logic          fbus, flbus, frbus, busy, done, cf;
    logic [W-1:0]  dout;

    shift_seq #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .start(start), .dir(dir), .cnt(cnt), .din(din),
        .sh_w(sh_w), .sh_cf(sh_cf), .sh_a(sh_a), .fbus(fbus), .flbus(flbus),
        .frbus(frbus), .busy(busy), .done(done), .dout(dout), .cf(cf)
    );

    always #5 clk = ~clk;

    // The machine's single-bit shifter.
    always_comb begin
        sh_w  = '0;
        sh_cf = 1'b0;
        if (flbus) begin
            sh_w  = {sh_a[W-2:0], sh_a[W-1]};
            sh_cf = sh_a[W-1];
        end else if (frbus) begin
            sh_w  = {sh_a[0], sh_a[W-1:1]};
            sh_cf = sh_a[0];
        end else if (fbus) begin
            sh_w  = sh_a;
        end
    end

    typedef struct {
        int           done_cyc;
        logic [W-1:0] dout;
        logic         cf;
    } exp_t;

    exp_t       exp_q[$];
    logic [4:0] exp_ctrl [int];   // {busy, done, fbus, flbus, frbus}
    int         cyc = 0;
    int         checks = 0;
    int         errors = 0;
    int         free_cyc = 0;
    int         last_rst_edge = -10;
    bit         mon_en = 1'b0;
    bit         pend = 1'b0;
    exp_t       pend_e;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, expv);
        end
    endtask

    // Reference: repeated rotate computed arithmetically.
    function automatic void model(input logic [W-1:0] d, input logic dr, input int n,
                                  output logic [W-1:0] r, output logic c);
        int v;
        v = int'(d);
        c = 1'b0;
        for (int k = 0; k < n; k++) begin
            if (dr == 1'b0) begin
                c = ((v >> (W - 1)) & 1) != 0;
                v = ((v << 1) | (v >> (W - 1))) & ((1 << W) - 1);
            end else begin
                c = (v & 1) != 0;
                v = (v >> 1) | ((v & 1) << (W - 1));
            end
        end
        r = v[W-1:0];
    endfunction

    task automatic issue(input logic [W-1:0] d, input logic dr, input logic [CW-1:0] n);
        int   s;
        exp_t e;
        @(negedge clk);
        din = d; dir = dr; cnt = n; start = 1'b1;
        s = cyc + 1;
        if (s >= free_cyc) begin
            for (int k = 0; k < int'(n); k++) exp_ctrl[s + k] = {1'b1, 1'b0, 1'b0, ~dr, dr};
            exp_ctrl[s + int'(n)] = 5'b11100;
            e.done_cyc = s + int'(n);
            model(d, dr, int'(n), e.dout, e.cf);
            exp_q.push_back(e);
            free_cyc = s + int'(n) + 2;
        end
        @(negedge clk);
        start = 1'b0;
        din = 8'($urandom); dir = 1'($urandom); cnt = 3'($urandom);
    endtask

    task automatic do_reset(input int ncyc);
        int   r;
        int   keys[$];
        exp_t keep[$];
        @(negedge clk);
        rst = 1'b1;
        r = cyc + 1;
        last_rst_edge = r;
        foreach (exp_ctrl[k]) if (k >= r) keys.push_back(k);
        foreach (keys[i]) exp_ctrl.delete(keys[i]);
        foreach (exp_q[i]) if (exp_q[i].done_cyc < r) keep.push_back(exp_q[i]);
        exp_q = keep;
        repeat (ncyc) @(negedge clk);
        rst = 1'b0;
        free_cyc = cyc + 1;
        chk("rst_dout", 32'(dout), 32'h0);
        chk("rst_cf", 32'(cf), 32'h0);
    endtask

    task automatic wait_idle();
        while (cyc < free_cyc) @(negedge clk);
        @(negedge clk);
    endtask

    // Monitor: per-cycle control lines, done timing, and result after done.
    always @(negedge clk) begin
        if (mon_en) begin
            chk("ctrl", 32'({busy, done, fbus, flbus, frbus}),
                32'(exp_ctrl.exists(cyc) ? exp_ctrl[cyc] : 5'd0));
            if (pend) begin
                pend = 1'b0;
                if (last_rst_edge != pend_e.done_cyc + 1) begin
                    chk("dout", 32'(dout), 32'(pend_e.dout));
                    chk("cf", 32'(cf), 32'(pend_e.cf));
                end
            end
            if (done) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_done", 32'h1, 32'h0);
                end else begin
                    pend_e = exp_q.pop_front();
                    chk("done_cycle", 32'(cyc), 32'(pend_e.done_cyc));
                    pend = 1'b1;
                end
            end
        end
    end

    initial begin
        do_reset(2);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_ctrl", 32'({fbus, flbus, frbus, done}), 32'h0);
        mon_en = 1'b1;

        issue(8'h81, 1'b0, 3'd1); wait_idle();
        issue(8'h01, 1'b1, 3'd3); wait_idle();
        issue(8'h01, 1'b0, 3'd7); wait_idle();
        issue(8'h5A, 1'b0, 3'd0); wait_idle();
        issue(8'h5A, 1'b1, 3'd0); wait_idle();

        // Start during SHIFT is ignored.
        issue(8'h3C, 1'b1, 3'd4);
        issue(8'hFF, 1'b0, 3'd2);
        wait_idle();

        // Start during the done cycle is ignored; the next cycle is accepted.
        issue(8'hA5, 1'b0, 3'd2);
        @(negedge clk);
        issue(8'h11, 1'b1, 3'd1);
        issue(8'h22, 1'b1, 3'd1);
        wait_idle();

        // Reset in the second SHIFT cycle abandons the operation.
        issue(8'hC3, 1'b1, 3'd5);
        do_reset(1);
        issue(8'hC3, 1'b1, 3'd5); wait_idle();

        for (int i = 0; i < 80; i++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            if ($urandom_range(0, 24) == 0) do_reset(int'($urandom_range(1, 2)));
            issue(8'($urandom), 1'($urandom), 3'($urandom));
        end
        wait_idle();
        repeat (3) @(negedge clk);
        chk("queue_empty", 32'(exp_q.size()), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/shift_seq.md
Name: shift_seq

Overview:
Multi-step rotate controller for the single-bit bus shifter of the model machine. It accepts a rotate request with a direction and a count, and sequences the shifter's control lines for that many steps. Each step's result is fed back to the shifter input. When the count is exhausted, the controller drives a pass-through cycle so the final value reaches the bus. The block sits between the microcontroller's control word and the shifter, and owns fbus/flbus/frbus exclusively.

Parameters:
WIDTH, 8, data width of the shifter path
CNT_W, 3, width of the rotate count; maximum count is 2**CNT_W-1

Ports:
clk  in  1  system clock, rising-edge
rst  in  1  reset; synchronous, active-high
start  in  1  request pulse; sampled only in IDLE
dir  in  1  0 = rotate left, 1 = rotate right; latched at start
cnt  in  CNT_W  number of single-bit rotate steps; latched at start
din  in  WIDTH  operand; latched at start
sh_w  in  WIDTH  shifter result
sh_cf  in  1  shifter carry out
sh_a  out  WIDTH  shifter operand; equals the internal accumulator
fbus  out  1  shifter pass-through select
flbus  out  1  shifter rotate-left select
frbus  out  1  shifter rotate-right select
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse in OUT state
dout  out  WIDTH  final result; held until next accepted start
cf  out  1  carry of last step; held until next accepted start

Behaviour:
- States: IDLE, SHIFT, OUT. Encoded in a 2-bit register; the unused code returns to IDLE on the next edge.
- Reset: on any edge with rst=1, state=IDLE, acc=0, remaining=0, dout=0, cf=0, dir_q=0. rst overrides start. An operation in progress is abandoned with no done pulse.
- Control lines are Moore outputs decoded from state and dir_q:
  - IDLE: fbus=flbus=frbus=0, so the shifter output floats.
  - SHIFT: flbus=~dir_q, frbus=dir_q, fbus=0.
  - OUT: fbus=1, others 0.
  - At most one control line is ever high; this is a checked invariant.
- IDLE with start=1:
  - Latch acc=din, dir_q=dir, remaining=cnt, clear cf.
  - If cnt!=0, go to SHIFT; else go to OUT.
- SHIFT, each edge:
  - acc<=sh_w, cf<=sh_cf, remaining<=remaining-1.
  - If remaining==1, go to OUT; else stay in SHIFT.
- OUT, for one cycle:
  - done=1; dout<=acc registered at this edge; go to IDLE.
  - The bus carries acc through the shifter pass-through during this cycle.
- Latency: start sampled at edge E. SHIFT occupies cycles E+1..E+cnt. done is high in cycle E+cnt+1. dout and cf are valid from the following edge onward.
- start while busy=1 is ignored and not queued. start in the same cycle done is high is also ignored; the earliest new accept is the cycle after OUT.
- cnt=0: no shift steps; cf stays 0; dout=din.
- Maximum count 2**CNT_W-1 must not wrap the remaining counter.
- sh_w/sh_cf are sampled only in SHIFT; values in other states are don't-care (may be Z).

Decomposition:
- Shared package shift_pkg holds:
  - state enum {IDLE, SHIFT, OUT} with 2-bit encoding;
  - constants DIR_LEFT=0, DIR_RIGHT=1;
  - default WIDTH/CNT_W.
- No sub-module needed. The bench instantiates the existing shifter and wires sh_w/sh_cf back to the controller, forming a closed loop.

Test Plan:
- din=0x81, dir=0, cnt=1 -> one SHIFT cycle with flbus=1, done at E+2, dout=0x03, cf=1.
- din=0x01, dir=1, cnt=3 -> frbus high for 3 cycles, dout=0x20, cf=0, done at E+4.
- din=0x01, dir=0, cnt=7 -> dout=0x80, cf=0, busy high for 8 cycles; remaining counter does not wrap.
- din=0x5A, cnt=0 -> no flbus/frbus; fbus=1 and done in cycle E+1; dout=0x5A, cf=0.
- start pulsed again during SHIFT with din=0xFF -> ignored; first operation's dout unchanged, and no second done.
- rst asserted in the second SHIFT cycle of a cnt=5 operation -> next cycle IDLE, all controls 0, dout=0, cf=0, no done; a subsequent start runs normally.
